alu_exec: RTL and testbench
===========================

# alu_exec

Registered ALU execution stage downstream of the ALU control decoder. Consumes the 4-bit `ALUCtl` code plus two operands under a start/done handshake, produces a registered result and zero flag. Logic ops complete in one cycle. An optional iterative shift-add multiplier holds the stage busy for `WIDTH` cycles.

## Interface
Parameters:
- `WIDTH`, 32, operand/result width (≥2, power of two)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high (`clock`, `reset`).
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `start`  in  1  request; sampled only when `busy`=0
- `ALUCtl`  in  4  operation code, captured with `start`
- `A`  in  WIDTH  operand A, captured with `start`
- `B`  in  WIDTH  operand B, captured with `start`
- `busy`  out  1  multi-cycle op in progress; `start` ignored
- `done`  out  1  one-cycle pulse: `ALUOut`/`Zero`/`Illegal` updated this cycle
- `ALUOut`  out  WIDTH  registered result, held until next completion
- `Zero`  out  1  registered (`ALUOut`==0)
- `Illegal`  out  1  registered: last completed op had an unsupported code

## Operation
- Codes:
  - 0 AND
  - 1 OR
  - 2 ADD
  - 6 SUB
  - 7 SLT (signed; result 1 or 0)
  - 12 NOR
  - 8 MUL (only with `ALU_MUL_EN`)
- Any other code: `ALUOut`=0, `Zero`=1, `Illegal`=1, single-cycle completion.
- ADD/SUB wrap modulo 2^WIDTH; no overflow flag.
- MUL returns the low WIDTH bits of the unsigned product. This equals the signed low half.
- FSM states:
  - IDLE
    - `start`=1 with a single-cycle code: compute, write outputs, pulse `done`, stay IDLE.
    - `start`=1 with MUL: latch A into multiplicand, B into multiplier, clear accumulator and counter, go to MUL.
  - MUL, each cycle:
    - If multiplier bit0=1, accumulator += multiplicand.
    - Multiplicand <<= 1; multiplier >>= 1; counter++.
    - On the WIDTH-th iteration: write `ALUOut` = final accumulator, pulse `done`, return to IDLE.
- `busy`=1 exactly while in MUL.
- Any `start` during MUL is dropped. It is not queued.
- `ALUCtl`/`A`/`B` changes after capture have no effect on the op in flight.
- Counter width: clog2(WIDTH)+1 bits.

## Timing
- Reset values: `busy`=0, `done`=0, `ALUOut`=0, `Zero`=1, `Illegal`=0. FSM=IDLE, counter=0, accumulator=0.
- Single-cycle op: `start` sampled at edge k gives `done`=1 and new `ALUOut` after edge k (latency 1).
- MUL: `start` at edge k gives `busy`=1 after edge k. Iterations run at edges k+1..k+WIDTH. After edge k+WIDTH: `done`=1, `busy`=0, result valid (latency WIDTH+1 edges). Back-to-back MUL throughput is one per WIDTH+1 cycles.
- `start` in the same cycle as a `done` pulse is accepted whenever `busy`=0.
- `done` is never high two cycles in a row unless a new `start` was accepted each cycle.
- `reset` asserted mid-MUL aborts the op at the next edge. All outputs return to reset values and no `done` is issued.
- `reset` and `start` both high: reset wins; the request is lost.

## Configuration
- `ALU_MUL_EN` defined:
  - Multiplier datapath, MUL state and counter are compiled in.
  - Code 8 performs the iterative multiply above.
- `ALU_MUL_EN` undefined:
  - No MUL state; `busy` is tied to 0.
  - Code 8 is treated as illegal: `ALUOut`=0, `Illegal`=1, `done` after 1 cycle.
  - Every op has latency 1.

## Test plan
- Reset: hold `reset` 2 cycles with `start`=1 -> `ALUOut`=0, `Zero`=1, `busy`=0, `done`=0 throughout.
- Single-cycle ops, WIDTH=32:
  - ADD 0xFFFFFFFF+1 -> `ALUOut`=0, `Zero`=1, `done` next cycle.
  - SUB 5-7 -> 0xFFFFFFFE.
  - SLT A=0xFFFFFFFF, B=1 -> 1.
  - NOR 0,0 -> 0xFFFFFFFF.
- Illegal code 5, A=3, B=4 -> `ALUOut`=0, `Illegal`=1, `Zero`=1, latency 1. A following ADD 1+1 -> `ALUOut`=2, `Illegal`=0.
- MUL (`ALU_MUL_EN`): 0x0001_0003 × 0x0000_0005 -> `busy` high 32 cycles, `done` at cycle 33, `ALUOut`=0x0005_000F. 0xFFFFFFFF × 0xFFFFFFFF -> 1. A `start` ADD issued mid-MUL is ignored.
- Back-to-back: `start` held high with ADD 2+3 then a MUL issued the same cycle `done` pulses -> ADD `done`, then MUL accepted, `busy` asserted next cycle.
- Reset mid-MUL at iteration 10 -> no `done`, `busy`=0 and `ALUOut`=0 next cycle. A new ADD 4+4 then completes with 8.

Source files
------------

// File: rtl/alu_exec.sv
// alu_exec: registered ALU stage; optional iterative shift-add multiplier when ALU_MUL_EN is defined.
module alu_exec #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUCtl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUOut,
  output logic             Zero,
  output logic             Illegal
);
  logic [WIDTH-1:0] res, out_q, out_d;
  logic res_ill, zero_q, zero_d, ill_q, ill_d, done_q, done_d;
  always_comb begin
    res = '0;
    res_ill = 1'b0;
    case (ALUCtl)
      4'd0:    res = A & B;
      4'd1:    res = A | B;
      4'd2:    res = A + B;
      4'd6:    res = A - B;
      4'd7:    res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
      4'd12:   res = ~(A | B);
      default: res_ill = 1'b1;
    endcase
  end
`ifdef ALU_MUL_EN
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic {IDLE, MUL} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign busy = state_q == MUL;
`else
  assign busy = 1'b0;
`endif
  always_comb begin
    out_d = out_q;
    zero_d = zero_q;
    ill_d = ill_q;
    done_d = 1'b0;
`ifdef ALU_MUL_EN
    state_d = state_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (state_q == MUL) begin
      acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
      mcand_d = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH - 1)) begin
        out_d = acc_d;
        zero_d = acc_d == '0;
        ill_d = 1'b0;
        done_d = 1'b1;
        state_d = IDLE;
      end
    end else if (start && ALUCtl == 4'd8) begin
      state_d = MUL;
      mcand_d = A;
      mplier_d = B;
      acc_d = '0;
      cnt_d = '0;
    end else
`endif
    if (start) begin
      out_d = res;
      zero_d = res == '0;
      ill_d = res_ill;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      out_q <= '0;
      zero_q <= 1'b1;
      ill_q <= 1'b0;
      done_q <= 1'b0;
`ifdef ALU_MUL_EN
      state_q <= IDLE;
      mcand_q <= '0;
      mplier_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
`endif
    end else begin
      out_q <= out_d;
      zero_q <= zero_d;
      ill_q <= ill_d;
      done_q <= done_d;
`ifdef ALU_MUL_EN
      state_q <= state_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
`endif
    end
  end
  assign ALUOut = out_q;
  assign Zero = zero_q;
  assign Illegal = ill_q;
  assign done = done_q;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: scoreboard bench for alu_exec; MUL vectors run when ALU_MUL_EN is defined.
module tb_alu_exec;
  localparam int W = 32;
  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [3:0] ALUCtl = '0;
  logic [W-1:0] A = '0, B = '0;
  logic busy, done, Zero, Illegal;
  logic [W-1:0] ALUOut;
  int checks = 0, errors = 0, cyc = 0;
  typedef struct {logic [W-1:0] out; logic z; logic il; int cyc;} exp_t;
  exp_t q[$];

  alu_exec #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .ALUCtl(ALUCtl), .A(A), .B(B),
    .busy(busy), .done(done), .ALUOut(ALUOut), .Zero(Zero), .Illegal(Illegal)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("ALUOut", ALUOut, e.out);
        chk("Zero", W'(Zero), W'(e.z));
        chk("Illegal", W'(Illegal), W'(e.il));
        chk("latency", W'(cyc), W'(e.cyc));
      end
    end
  end

  // Drives start for one cycle at a negedge; expected result is queued with its completion cycle.
  task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] r, input logic z, input logic il, input int lat);
    ALUCtl = c; A = a; B = b; start = 1'b1;
    q.push_back('{r, z, il, cyc + lat});
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_mul(input bit drop);
    for (int i = 0; i < W; i++) begin
      chk("busy_mul", W'(busy), 1);
      if (drop && i == 5) begin
        start = 1'b1; ALUCtl = 4'd2; A = 7; B = 9;
      end else start = 1'b0;
      @(negedge clock);
    end
    start = 1'b0;
    chk("busy_after_mul", W'(busy), 0);
  endtask

  initial begin
    start = 1'b1; ALUCtl = 4'd2; A = 1; B = 1;
    repeat (2) begin
      @(negedge clock);
      chk("rst_done", W'(done), 0);
      chk("rst_busy", W'(busy), 0);
      chk("rst_out", ALUOut, 0);
      chk("rst_zero", W'(Zero), 1);
      chk("rst_ill", W'(Illegal), 0);
    end
    start = 1'b0;
    reset = 1'b0;
    @(negedge clock);
    issue(4'd2, 32'hFFFF_FFFF, 32'h1, 32'h0, 1, 0, 1);
    issue(4'd6, 32'd5, 32'd7, 32'hFFFF_FFFE, 0, 0, 1);
    issue(4'd7, 32'hFFFF_FFFF, 32'd1, 32'd1, 0, 0, 1);
    issue(4'd7, 32'd1, 32'hFFFF_FFFF, 32'd0, 1, 0, 1);
    issue(4'd12, 32'd0, 32'd0, 32'hFFFF_FFFF, 0, 0, 1);
    issue(4'd0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 1);
    issue(4'd1, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F, 0, 0, 1);
    issue(4'd5, 32'd3, 32'd4, 32'd0, 1, 1, 1);
    issue(4'd2, 32'd1, 32'd1, 32'd2, 0, 0, 1);
    @(negedge clock);
`ifdef ALU_MUL_EN
    issue(4'd8, 32'h0001_0003, 32'h5, 32'h0005_000F, 0, 0, W + 1);
    wait_mul(1);
    issue(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 0, 0, W + 1);
    wait_mul(0);
    issue(4'd2, 32'd2, 32'd3, 32'd5, 0, 0, 1);
    issue(4'd8, 32'd6, 32'd7, 32'd42, 0, 0, W + 1);
    wait_mul(0);
    ALUCtl = 4'd8; A = 32'd9; B = 32'd9; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    chk("busy_before_abort", W'(busy), 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_busy", W'(busy), 0);
    chk("abort_out", ALUOut, 0);
    chk("abort_done", W'(done), 0);
    chk("abort_zero", W'(Zero), 1);
    repeat (W + 2) begin
      @(negedge clock);
      chk("abort_no_done", W'(done), 0);
    end
`else
    issue(4'd8, 32'd3, 32'd4, 32'd0, 1, 1, 1);
    chk("busy_tied", W'(busy), 0);
`endif
    issue(4'd2, 32'd4, 32'd4, 32'd8, 0, 0, 1);
    for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clock);
    repeat (3) @(negedge clock);
    chk("pending", W'(q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
